cordic_rotate_iter: RTL

- Iterative CORDIC rotation-mode core. Computes unscaled cos/sin of a folded phase, one micro-rotation per clock.
- Sits directly upstream of the quadrant post-correction stage in the cosine/sine generator.
- Drives cos_pre, sin_pre and the quadrant tag consumed by that stage.
- The quadrant tag rides alongside the computation unchanged.

---
 rtl/cordic_pkg.sv | 41 ++++
 rtl/cordic_atan_lut.sv | 17 +
 rtl/cordic_rotate_iter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and types for the iterative CORDIC rotator.
// Angles are Q8.16 radians.
package cordic_pkg;

  localparam int HALF_PI_Q16 = 102944;
  localparam int GAIN_Q16    = 107922;
  localparam int ATAN_N      = 20;

  typedef enum logic {
    IDLE = 1'b0,
    ROT  = 1'b1
  } state_e;

  // atan(2^-i) in Q8.16 for i = 0..19
  function automatic logic [23:0] atan_q16(input logic [4:0] idx);
    logic [23:0] a;
    unique case (idx)
      5'd0:    a = 24'd51472;
      5'd1:    a = 24'd30386;
      5'd2:    a = 24'd16055;
      5'd3:    a = 24'd8150;
      5'd4:    a = 24'd4091;
      5'd5:    a = 24'd2047;
      5'd6:    a = 24'd1024;
      5'd7:    a = 24'd512;
      5'd8:    a = 24'd256;
      5'd9:    a = 24'd128;
      5'd10:   a = 24'd64;
      5'd11:   a = 24'd32;
      5'd12:   a = 24'd16;
      5'd13:   a = 24'd8;
      5'd14:   a = 24'd4;
      5'd15:   a = 24'd2;
      5'd16:   a = 24'd1;
      5'd17:   a = 24'd1;
      default: a = 24'd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational micro-rotation index to angle lookup.
// Output is the Q8.16 arctangent zero-extended to DATA_W.
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic [4:0]        idx,
  output logic [DATA_W-1:0] angle
);

  // Table read, indices past the table give zero
  always_comb begin
    angle = DATA_W'(atan_q16(idx));
  end

endmodule

// File: rtl/cordic_rotate_iter.sv
// Iterative rotation-mode CORDIC, one micro-rotation per clock.
// Build option: define CORDIC_ROUND_EN to round shifted terms.
module cordic_rotate_iter
  import cordic_pkg::*;
#(
  parameter int DATA_W  = 24,
  parameter int ITER    = 16,
  parameter int X_INIT  = 100_000,
  parameter int HALF_PI = HALF_PI_Q16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] phase,
  input  logic [1:0]               quadrant_in,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] cos_pre,
  output logic signed [DATA_W-1:0] sin_pre,
  output logic [1:0]               quadrant
);

  localparam int XW = DATA_W + 2;
  localparam logic [4:0] LAST = 5'(ITER - 1);
  localparam logic signed [DATA_W-1:0] PH_MAX =
    DATA_W'(HALF_PI);
  localparam logic signed [DATA_W-1:0] PH_MIN =
    DATA_W'(-HALF_PI);
  localparam logic signed [XW-1:0] SAT_P =
    XW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_N = -SAT_P;

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic signed [XW-1:0] x_q, x_d;
  logic signed [XW-1:0] y_q, y_d;
  logic signed [DATA_W-1:0] z_q, z_d;
  logic [4:0] i_q, i_d;
  logic [1:0] tag_q, tag_d;
  logic signed [DATA_W-1:0] cos_q, cos_d;
  logic signed [DATA_W-1:0] sin_q, sin_d;
  logic [1:0] quad_q, quad_d;

  logic [DATA_W-1:0] atan_a;
  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] xs, ys;
  logic signed [XW-1:0] xn, yn;
  logic signed [DATA_W-1:0] zn;
  logic signed [DATA_W-1:0] ph_c;

  function automatic logic [DATA_W-1:0] sat(
    input logic signed [XW-1:0] v
  );
    logic [DATA_W-1:0] r;
    if (v > SAT_P)
      r = SAT_P[DATA_W-1:0];
    else if (v < SAT_N)
      r = SAT_N[DATA_W-1:0];
    else
      r = v[DATA_W-1:0];
    return r;
  endfunction

  cordic_atan_lut #(
    .DATA_W (DATA_W)
  ) u_lut (
    .idx   (i_q),
    .angle (atan_a)
  );

`ifdef CORDIC_ROUND_EN
  logic [4:0] im1;
  assign im1 = i_q - 5'd1;

  // Half-LSB bias so the arithmetic shift rounds to nearest
  always_comb begin
    rnd = '0;
    if (i_q != 5'd0)
      rnd[im1] = 1'b1;
  end
`else
  assign rnd = '0;
`endif

  // Phase clamp applied at accept
  always_comb begin
    ph_c = phase;
    if (phase > PH_MAX)
      ph_c = PH_MAX;
    else if (phase < PH_MIN)
      ph_c = PH_MIN;
  end

  // One micro-rotation, direction from sign of residual angle
  always_comb begin
    xs = (x_q + rnd) >>> i_q;
    ys = (y_q + rnd) >>> i_q;
    if (!z_q[DATA_W-1]) begin
      xn = x_q - ys;
      yn = y_q + xs;
      zn = z_q - $signed(atan_a);
    end else begin
      xn = x_q + ys;
      yn = y_q - xs;
      zn = z_q + $signed(atan_a);
    end
  end

  // Control: accept, iterate, publish
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    i_d         = i_q;
    tag_d       = tag_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    quad_d      = quad_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d        = XW'(X_INIT);
          y_d        = '0;
          z_d        = ph_c;
          i_d        = '0;
          tag_d      = quadrant_in;
          state_d    = ROT;
          in_ready_d = 1'b0;
        end
      end
      ROT: begin
        x_d = xn;
        y_d = yn;
        z_d = zn;
        i_d = i_q + 5'd1;
        if (i_q == LAST) begin
          cos_d       = sat(xn);
          sin_d       = sat(yn);
          quad_d      = tag_q;
          out_valid_d = 1'b1;
          i_d         = '0;
          state_d     = IDLE;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      tag_q       <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      quad_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      i_q         <= i_d;
      tag_q       <= tag_d;
      cos_q       <= cos_d;
      sin_q       <= sin_d;
      quad_q      <= quad_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign cos_pre   = cos_q;
  assign sin_pre   = sin_q;
  assign quadrant  = quad_q;

endmodule
